// File: rtl/conv1_dense_pkg.sv
// Shared constants and helpers for the conv1 layer1 dense collect path.
package conv1_dense_pkg;

  localparam int DATA_W  = 16;
  localparam int VEC_LEN = 64;
  localparam int IDX_W   = $clog2(VEC_LEN);

  typedef logic [IDX_W-1:0] idx_t;

  // Signed add one bit wider than the operands, then clamp back to DATA_W.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1])
      sat_add = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      sat_add = s[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/conv1_pingpong_bank.sv
// Two element banks filled alternately; a full bank is presented until accepted.
module conv1_pingpong_bank
  import conv1_dense_pkg::*;
#(
  parameter int DATA_W  = conv1_dense_pkg::DATA_W,
  parameter int VEC_LEN = conv1_dense_pkg::VEC_LEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      hold,
  input  logic                      wr_v,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_rdy,
  output logic                      rd_v,
  output logic [DATA_W*VEC_LEN-1:0] rd_vec,
  output logic                      rd_fire,
  output logic                      wr_drop
);

  localparam idx_t LAST = idx_t'(VEC_LEN - 1);

  logic [DATA_W-1:0] mem [2][VEC_LEN];
  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic              wr_bank;
  logic              rd_bank;
  idx_t              wr_cnt;
  logic              wr_live;
  logic              wr_ok;

  assign rd_v    = full[rd_bank];
  assign rd_fire = rd_v && rd_rdy && !hold && !clr;
  assign wr_live = wr_v && !hold && !clr;
  // A full bank still accepts the write if it is being released on this same edge.
  assign wr_ok   = wr_live && (!full[wr_bank] || (rd_fire && (rd_bank == wr_bank)));
  assign wr_drop = wr_live && !wr_ok;

  always_comb begin
    full_nxt = full;
    if (rd_fire)
      full_nxt[rd_bank] = 1'b0;
    if (wr_ok && (wr_cnt == LAST))
      full_nxt[wr_bank] = 1'b1;
  end

  always_comb begin
    rd_vec = '0;
    for (int i = 0; i < VEC_LEN; i++)
      rd_vec[i*DATA_W +: DATA_W] = mem[rd_bank][i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < VEC_LEN; i++)
          mem[b][i] <= '0;
    end else if (clr) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
    end else begin
      full <= full_nxt;
      if (rd_fire)
        rd_bank <= ~rd_bank;
      if (wr_ok) begin
        mem[wr_bank][wr_cnt] <= wr_data;
        if (wr_cnt == LAST) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + idx_t'(1);
        end
      end
    end
  end

endmodule

// File: rtl/conv1_layer1_dense_collect.sv
// Adds bias with saturation and optional ReLU to serial adder-tree results,
// then packs them into ping-pong vectors for the 1x64 multiply stage.
module conv1_layer1_dense_collect
  import conv1_dense_pkg::*;
#(
  parameter int DATA_W  = conv1_dense_pkg::DATA_W,
  parameter int VEC_LEN = conv1_dense_pkg::VEC_LEN,
  parameter int RELU_EN = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      halt,
  input  logic [DATA_W-1:0]         bias_in,
  input  logic                      data_v,
  input  logic [DATA_W-1:0]         add_res_w,
  output logic                      out_v,
  input  logic                      out_rdy,
  output logic [DATA_W*VEC_LEN-1:0] out_vec,
  output logic [15:0]               vec_cnt,
  output logic                      overflow
);

  logic [DATA_W-1:0] bias;
  logic [DATA_W-1:0] s1_data;
  logic              s1_v;
  logic [DATA_W-1:0] s1_res;
  logic              rd_fire;
  logic              wr_drop;

  always_comb begin
    s1_res = sat_add(add_res_w, bias);
    if ((RELU_EN != 0) && s1_res[DATA_W-1])
      s1_res = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bias     <= '0;
      s1_data  <= '0;
      s1_v     <= 1'b0;
      vec_cnt  <= '0;
      overflow <= 1'b0;
    end else if (start) begin
      bias     <= bias_in;
      s1_v     <= 1'b0;
      vec_cnt  <= '0;
      overflow <= 1'b0;
    end else if (!halt) begin
      s1_v <= data_v;
      if (data_v)
        s1_data <= s1_res;
      if (rd_fire)
        vec_cnt <= vec_cnt + 16'd1;
      if (wr_drop)
        overflow <= 1'b1;
    end
  end

  conv1_pingpong_bank #(
    .DATA_W  (DATA_W),
    .VEC_LEN (VEC_LEN)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .clr     (start),
    .hold    (halt),
    .wr_v    (s1_v),
    .wr_data (s1_data),
    .rd_rdy  (out_rdy),
    .rd_v    (out_v),
    .rd_vec  (out_vec),
    .rd_fire (rd_fire),
    .wr_drop (wr_drop)
  );

endmodule

// File: tb/tb_conv1_layer1_dense_collect.sv
// Scoreboard bench: expected vectors are queued by the stimulus and popped by a handshake monitor.
module tb_conv1_layer1_dense_collect;

  localparam int DW = 16;
  localparam int VL = 64;
  typedef logic [DW*VL-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst, start, halt, data_v, out_rdy;
  logic [DW-1:0] bias_in, add_res_w;
  logic          out_v, overflow, out_v2, overflow2;
  vec_t          out_vec, out_vec2;
  logic [15:0]   vec_cnt, vec_cnt2;

  int   tests = 0;
  int   fails = 0;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  conv1_layer1_dense_collect #(.DATA_W(DW), .VEC_LEN(VL), .RELU_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .bias_in(bias_in),
    .data_v(data_v), .add_res_w(add_res_w), .out_v(out_v), .out_rdy(out_rdy),
    .out_vec(out_vec), .vec_cnt(vec_cnt), .overflow(overflow)
  );

  conv1_layer1_dense_collect #(.DATA_W(DW), .VEC_LEN(VL), .RELU_EN(0)) dut_norelu (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .bias_in(bias_in),
    .data_v(data_v), .add_res_w(add_res_w), .out_v(out_v2), .out_rdy(out_rdy),
    .out_vec(out_vec2), .vec_cnt(vec_cnt2), .overflow(overflow2)
  );

  function automatic vec_t fill(input logic [DW-1:0] v);
    vec_t r;
    for (int i = 0; i < VL; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic int first_diff(input vec_t a, input vec_t b);
    for (int i = 0; i < VL; i++)
      if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
    return -1;
  endfunction

  // Handshake monitor: a vector transfers at the next edge when this holds.
  always @(negedge clk) begin
    if (!rst && !start && !halt && out_v && out_rdy) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_vec got elem0=%h, no vector expected", out_vec[DW-1:0]);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        if (out_vec !== e) begin
          int k;
          fails++;
          k = first_diff(out_vec, e);
          $display("FAIL vec_data elem%0d got %h expected %h", k,
                   out_vec[k*DW +: DW], e[k*DW +: DW]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input vec_t act, input vec_t exp);
    tests++;
    if (act !== exp) begin
      int k;
      fails++;
      k = first_diff(act, exp);
      $display("FAIL %s elem%0d got %h expected %h", nm, k, act[k*DW +: DW], exp[k*DW +: DW]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] v);
    data_v    = 1'b1;
    add_res_w = v;
    step();
    data_v    = 1'b0;
  endtask

  task automatic do_start(input logic [DW-1:0] b);
    start   = 1'b1;
    bias_in = b;
    step();
    start   = 1'b0;
  endtask

  // Wait (bounded) for a presented vector and accept it.
  task automatic take();
    int k = 0;
    while (!out_v && k < 20) begin
      step();
      k++;
    end
    if (!out_v) begin
      tests++;
      fails++;
      $display("FAIL take_timeout out_v=%b expected 1", out_v);
    end else begin
      out_rdy = 1'b1;
      step();
      out_rdy = 1'b0;
    end
  endtask

  initial begin
    vec_t v0, v1, v2;
    rst = 1'b1; start = 1'b0; halt = 1'b0; data_v = 1'b0; out_rdy = 1'b0;
    bias_in = '0; add_res_w = '0;
    step(); step();
    rst = 1'b0;
    chk("reset_out_v", {31'd0, out_v}, 32'd0);
    chk("reset_out_vec_lo", out_vec[31:0], 32'd0);
    chk("reset_vec_cnt", {16'd0, vec_cnt}, 32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);

    // Basic fill with bias 0x0010 and 2-edge latency.
    do_start(16'h0010);
    exp_q.push_back(fill(16'h0011));
    for (int i = 0; i < VL; i++) send(16'h0001);
    chk("latency_edge1_out_v", {31'd0, out_v}, 32'd0);
    step();
    chk("latency_edge2_out_v", {31'd0, out_v}, 32'd1);
    take();
    chk("basic_vec_cnt", {16'd0, vec_cnt}, 32'd1);
    chk("basic_out_v_low", {31'd0, out_v}, 32'd0);

    // Positive saturation.
    do_start(16'h7FF0);
    chk("start_clears_vec_cnt", {16'd0, vec_cnt}, 32'd0);
    v0 = fill(16'h7FF0);
    v0[DW-1:0] = 16'h7FFF;
    exp_q.push_back(v0);
    send(16'h0100);
    for (int i = 1; i < VL; i++) send(16'h0000);
    take();

    // Negative saturation, with and without ReLU.
    do_start(16'h8000);
    exp_q.push_back(fill(16'h0000));
    for (int i = 0; i < VL; i++) send(16'hFFFF);
    step();
    chk_vec("norelu_neg_sat", out_vec2, fill(16'h8000));
    take();

    // Backpressure: two full banks, then a dropped sample.
    do_start(16'h0000);
    for (int i = 0; i < VL; i++) begin
      v0[i*DW +: DW] = 16'(i);
      v1[i*DW +: DW] = 16'(i + VL);
    end
    exp_q.push_back(v0);
    exp_q.push_back(v1);
    for (int i = 0; i < 2*VL; i++) send(16'(i));
    step(); step();
    chk("bp_out_v", {31'd0, out_v}, 32'd1);
    chk_vec("bp_vec_hold_a", out_vec, v0);
    chk("bp_overflow_clear", {31'd0, overflow}, 32'd0);
    step(); step(); step();
    chk_vec("bp_vec_hold_b", out_vec, v0);
    send(16'h1234);
    step(); step();
    chk("bp_overflow_set", {31'd0, overflow}, 32'd1);
    out_rdy = 1'b1;
    step(); step();
    out_rdy = 1'b0;
    chk("bp_vec_cnt", {16'd0, vec_cnt}, 32'd2);
    chk("bp_drained_out_v", {31'd0, out_v}, 32'd0);
    exp_q.push_back(fill(16'h0005));
    for (int i = 0; i < VL; i++) send(16'h0005);
    take();

    // Same-edge free: stage-2 write into the bank released on that edge.
    do_start(16'h0000);
    for (int i = 0; i < VL; i++) begin
      v0[i*DW +: DW] = 16'(i + 256);
      v1[i*DW +: DW] = 16'(i + 320);
    end
    v2 = fill(16'h0888);
    v2[DW-1:0] = 16'h0777;
    exp_q.push_back(v0);
    exp_q.push_back(v1);
    exp_q.push_back(v2);
    for (int i = 0; i < 2*VL; i++) send(16'(i + 256));
    step();
    send(16'h0777);
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    chk("same_edge_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 1; i < VL; i++) send(16'h0888);
    take();
    take();
    chk("same_edge_vec_cnt", {16'd0, vec_cnt}, 32'd3);
    chk("same_edge_overflow_end", {31'd0, overflow}, 32'd0);

    // Halt mid-vector with a pending full bank and out_rdy asserted.
    do_start(16'h0000);
    exp_q.push_back(fill(16'h0003));
    for (int i = 0; i < VL; i++) send(16'h0003);
    for (int i = 0; i < VL; i++) v0[i*DW +: DW] = 16'(i + 1);
    exp_q.push_back(v0);
    for (int i = 0; i < 10; i++) send(16'(i + 1));
    halt = 1'b1; data_v = 1'b1; add_res_w = 16'hDEAD; out_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("halt_out_v_%0d", c), {31'd0, out_v}, 32'd1);
    end
    chk("halt_vec_cnt", {16'd0, vec_cnt}, 32'd0);
    halt = 1'b0; data_v = 1'b0; out_rdy = 1'b0;
    for (int i = 10; i < VL; i++) send(16'(i + 1));
    take();
    take();
    chk("halt_vec_cnt_end", {16'd0, vec_cnt}, 32'd2);

    // Start mid-vector discards the partial vector; data_v on the start cycle is ignored.
    do_start(16'h0000);
    for (int i = 0; i < 30; i++) send(16'h0AAA);
    data_v = 1'b1; add_res_w = 16'h0BBB;
    do_start(16'h0002);
    data_v = 1'b0;
    for (int i = 0; i < VL; i++) v0[i*DW +: DW] = 16'(i + 2);
    exp_q.push_back(v0);
    for (int i = 0; i < VL; i++) send(16'(i));
    take();
    chk("restart_vec_cnt", {16'd0, vec_cnt}, 32'd1);

    step(); step();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv1_layer1_dense_collect.md
Name: conv1_layer1_dense_collect

Overview:
Downstream stage of the 25-wise adder tree in the conv1 layer1 dense path. It consumes the serial 16-bit dot-product results and adds a per-layer bias with saturation. It then applies optional ReLU and packs VEC_LEN results into a wide vector for the following 1x64 parallel-multiply stage. Two ping-pong banks let the adder tree keep streaming while a packed vector waits on the downstream ready.

Parameters:
DATA_W, 16, width of one signed result element
VEC_LEN, 64, elements packed per output vector
RELU_EN, 1, 1 = clamp negative results to 0

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; clears counters/flags, captures bias_in
halt  in  1  global freeze
bias_in  in  DATA_W  signed bias, sampled on start
data_v  in  1  add_res_w valid (from adder tree add_res_v_w)
add_res_w  in  DATA_W  signed adder-tree result
out_v  out  1  packed vector valid
out_rdy  in  1  downstream accepts vector
out_vec  out  DATA_W*VEC_LEN  packed vector, element 0 in LSBs
vec_cnt  out  16  completed vectors handed off, wraps at 65535
overflow  out  1  sticky; a sample was dropped

Behaviour:
- Reset (rst=1 at edge): out_v=0, out_vec=0, vec_cnt=0, overflow=0, bias reg=0, wr_cnt=0, wr_bank=0, rd_bank=0, both bank-full flags=0, stage-1 valid=0.
- Priority at each edge: rst > start > halt > normal.
- start: same clearing as reset except bank data is kept. Also loads bias reg from bias_in. A data_v on the start cycle is ignored.
- halt=1: all state holds. data_v is ignored (not captured, no overflow). out_v holds its value. out_rdy is ignored, so no handshake completes.
- Stage 1, registered at the edge sampling data_v:
  - sum = sext17(add_res_w) + sext17(bias).
  - Saturate to [-32768, 32767].
  - If RELU_EN and the result is negative, set it to 0.
  - Store in s1_data with s1_v=1.
- Stage 2, on the next edge when s1_v=1:
  - Write s1_data to bank[wr_bank][wr_cnt] and increment wr_cnt.
  - When wr_cnt==VEC_LEN-1 is written: set full[wr_bank], toggle wr_bank, set wr_cnt=0.
- Latency: out_v is high in the cycle after the second edge following sampling of the final element (2-edge latency).
- Overflow: if full[wr_bank]=1 at stage 2 and that bank is not freed on the same edge, drop the sample. Set overflow=1, and wr_cnt holds.
- Same-edge free: if out_v&&out_rdy frees bank X on the same edge that stage 2 writes into bank X, the write is accepted. Flags net to "not full"; data is written.
- Output:
  - out_v = full[rd_bank]; out_vec = bank[rd_bank] contents.
  - On out_v&&out_rdy: clear full[rd_bank], toggle rd_bank, increment vec_cnt (mod 2^16).
  - out_vec is stable while out_v=1 and out_rdy=0.
  - Back-to-back: both banks full and out_rdy held high gives out_v=1 on two consecutive cycles.
- data_v may be asserted every cycle; there is no upstream backpressure.
- Reset or start mid-vector discards the partial vector and any pending full banks.

Decomposition:
- Shared package conv1_dense_pkg: DATA_W, VEC_LEN, sat_add function (17-bit add with saturate to DATA_W), and a bank-index typedef for the log2(VEC_LEN) counter.
- One natural sub-module: conv1_pingpong_bank, holding two banks with the write port, full flags and read mux.
- Bias/saturation/ReLU stays in the top module.

Test Plan:
- Reset then start with bias_in=0x0010; stream 64 samples of value 1 on consecutive cycles -> out_v rises 2 edges after the 64th sample; every element = 0x0011; vec_cnt=1 after out_rdy.
- Saturation: bias=0x7FF0, sample 0x0100 -> element 0x7FFF. With bias=0x8000, sample 0xFFFF, RELU_EN=1 -> element 0x0000; with RELU_EN=0 -> 0x8000.
- Backpressure: out_rdy=0, stream 128 samples -> both banks full, out_vec stable, overflow=0. 129th sample -> overflow=1, sample dropped. Then out_rdy=1 for 2 cycles -> 2 handshakes, vec_cnt=2.
- Same-edge free: both banks full; stage-2 write and out_rdy=1 coincide -> write accepted, overflow stays 0.
- halt asserted for 5 cycles mid-vector with data_v=1 -> wr_cnt unchanged, no samples captured, out_v held. After release, the vector completes with the correct count.
- start pulse after 30 samples -> wr_cnt=0, partial data discarded; the next 64 samples form vector 0 with the new bias.
